mdio_frame_engine: RTL and testbench

MDIO_FRAME_ENGINE -- requirements
Module: mdio_frame_engine

---
 rtl/mdio_frame_engine.sv | 124 ++++++++++++
 tb/tb_mdio_frame_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_frame_engine.sv
// MDIO (IEEE 802.3 clause 22) management frame master: preamble, header, turnaround and data.
// Define MDIO_CLAUSE45_EN for clause 45 framing (ST=00, all four opcodes accepted).
module mdio_frame_engine #(
   parameter int CLK_DIV      = 4,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [1:0]  i_op,
   input  logic [4:0]  i_phy_addr,
   input  logic [4:0]  i_reg_addr,
   input  logic [15:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_rdata,
   output logic        o_err,
   output logic        o_mdc,
   inout  wire         mdio_inout
);

   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  div_cnt;
   logic [5:0]  bit_cnt;
   logic [5:0]  state_len;
   logic [31:0] tx;
   logic        is_read;
   logic        accept, op_ok, op_rd;
   logic [1:0]  st_field;
   logic        tick, rise, fall, last_bit;
   logic        oe, dout;

`ifdef MDIO_CLAUSE45_EN
   assign st_field = 2'b00;
   assign op_ok    = 1'b1;
   assign op_rd    = i_op[1];
`else
   assign st_field = 2'b01;
   assign op_ok    = (i_op == 2'b01) || (i_op == 2'b10);
   assign op_rd    = (i_op == 2'b10);
`endif

   assign o_busy   = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);
   assign o_done   = (state == DONE);
   assign accept   = i_start && !o_busy;
   assign tick     = o_busy && (div_cnt == 8'(CLK_DIV - 1));
   assign rise     = tick && !o_mdc;
   assign fall     = tick && o_mdc;
   assign last_bit = (bit_cnt == state_len - 6'd1);

   // Read frames release the line from the first turnaround bit onward.
   assign oe         = (state == PRE) || (state == HDR) ||
                       (((state == TA) || (state == DATA)) && !is_read);
   assign dout       = (state == PRE) ? 1'b1 : tx[31];
   assign mdio_inout = oe ? dout : 1'bz;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      state_len = 6'd16;
      case (state)
         IDLE, DONE: begin
            if (!accept)                state_nxt = IDLE;
            else if (!op_ok)            state_nxt = DONE;
            else if (PREAMBLE_LEN == 0) state_nxt = HDR;
            else                        state_nxt = PRE;
         end
         PRE: begin
            state_len = 6'(PREAMBLE_LEN);
            if (fall && last_bit) state_nxt = HDR;
         end
         HDR: begin
            state_len = 6'd14;
            if (fall && last_bit) state_nxt = TA;
         end
         TA: begin
            state_len = 6'd2;
            if (fall && last_bit) state_nxt = DATA;
         end
         DATA: begin
            if (fall && last_bit) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         o_mdc   <= 1'b0;
         tx      <= '0;
         is_read <= 1'b0;
         o_rdata <= '0;
         o_err   <= 1'b0;
      end else if (accept) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         o_mdc   <= 1'b0;
         tx      <= {st_field, i_op, i_phy_addr, i_reg_addr, 2'b10, i_wdata};
         is_read <= op_rd;
         o_err   <= !op_ok;
      end else if (o_busy) begin
         div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
         if (tick) o_mdc <= !o_mdc;
         // PHY-driven bits are captured on the MDC rising edge.
         if (rise && is_read && (state == TA) && (bit_cnt == 6'd1))
            o_err <= mdio_inout;
         if (rise && is_read && (state == DATA))
            o_rdata <= {o_rdata[14:0], mdio_inout};
         if (fall) begin
            bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
            if (state != PRE) tx <= {tx[30:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_mdio_frame_engine.sv
// Directed bench for mdio_frame_engine: write/read frames, PHY model, reset abort, opcode handling.
module tb_mdio_frame_engine;
   localparam int DIV = 2;
   localparam int PL  = 32;
`ifdef MDIO_CLAUSE45_EN
   localparam logic [1:0] ST = 2'b00;
`else
   localparam logic [1:0] ST = 2'b01;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   logic [1:0]  op = '0;
   logic [4:0]  pa = '0;
   logic [4:0]  ra = '0;
   logic [15:0] wd = '0;
   logic        busy_a, done_a, err_a, mdc_a;
   logic        busy_b, done_b, err_b, mdc_b;
   logic [15:0] rdata_a, rdata_b;
   logic        start_a, start_b;
   wire         mdio_a;
   wire         mdio_b;
   logic        m_busy, m_done, m_mdc, m_mdio;

   logic        phy_en = 1'b0;
   logic        phy_oe = 1'b0;
   logic        phy_d = 1'b0;
   logic        phy_pm = 1'b0;
   logic [15:0] phy_data = '0;
   int          phy_rise = 0;
   int          nb;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pullup (mdio_a);
   pullup (mdio_b);
   assign mdio_a = phy_oe ? phy_d : 1'bz;

   assign start_a = start && !sel;
   assign start_b = start && sel;
   assign m_busy  = sel ? busy_b : busy_a;
   assign m_done  = sel ? done_b : done_a;
   assign m_mdc   = sel ? mdc_b  : mdc_a;
   assign m_mdio  = sel ? mdio_b : mdio_a;

   mdio_frame_engine #(.CLK_DIV(DIV), .PREAMBLE_LEN(PL)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_op(op),
      .i_phy_addr(pa), .i_reg_addr(ra), .i_wdata(wd),
      .o_busy(busy_a), .o_done(done_a), .o_rdata(rdata_a), .o_err(err_a),
      .o_mdc(mdc_a), .mdio_inout(mdio_a)
   );

   mdio_frame_engine #(.CLK_DIV(DIV), .PREAMBLE_LEN(0)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_op(op),
      .i_phy_addr(pa), .i_reg_addr(ra), .i_wdata(wd),
      .o_busy(busy_b), .o_done(done_b), .o_rdata(rdata_b), .o_err(err_b),
      .o_mdc(mdc_b), .mdio_inout(mdio_b)
   );

   // PHY model: drives TA bit 2 and the data bits, changing only after MDC falls.
   always @(negedge clk) begin
      if (!busy_a) begin
         phy_rise = 0;
         phy_oe   = 1'b0;
      end else begin
         if (!phy_pm && mdc_a) phy_rise++;
         if (phy_pm && !mdc_a && phy_en) begin
            nb = phy_rise + 1;
            if (nb == PL + 16) begin
               phy_oe = 1'b1;
               phy_d  = 1'b0;
            end else if (nb > PL + 16 && nb <= PL + 32) begin
               phy_oe = 1'b1;
               phy_d  = phy_data[PL + 32 - nb];
            end else begin
               phy_oe = 1'b0;
            end
         end
      end
      phy_pm = mdc_a;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called at a negedge; returns the line value seen at each MDC rise and the busy-to-done time.
   task automatic do_frame(input logic [1:0] f_op, input logic [4:0] f_pa, input logic [4:0] f_ra,
                           input logic [15:0] f_wd, input int inj,
                           output logic [63:0] bits, output int nrise, output int cyc,
                           output logic busy0, output logic busy_end);
      logic pm;
      op = f_op; pa = f_pa; ra = f_ra; wd = f_wd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy0 = m_busy;
      bits = '0; nrise = 0; cyc = 0; pm = 1'b0;
      while (!m_done && cyc < 2000) begin
         if (m_mdc && !pm) begin
            bits = {bits[62:0], m_mdio};
            nrise++;
         end
         pm = m_mdc;
         if (cyc == inj) begin
            op = 2'b10; pa = 5'h1F; wd = 16'hDEAD; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      busy_end = m_busy;
   endtask

   initial begin
      logic [63:0] bits;
      int nrise, cyc, cnt;
      logic b0, be, pm;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_rdata", rdata_a, 16'h0000);
      check("rst_err", err_a, 1'b0);
      check("rst_mdc", mdc_a, 1'b0);
      check("rst_line_z", mdio_a, 1'b1);

      // Clause 22 write
      do_frame(2'b01, 5'h01, 5'h00, 16'h1140, -1, bits, nrise, cyc, b0, be);
      check("wr_bits", bits, {32'hFFFF_FFFF, ST, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140});
      check("wr_nrise", nrise, 64);
      check("wr_cycles", cyc, 256);
      check("wr_busy_rise", b0, 1'b1);
      check("wr_busy_at_done", be, 1'b0);
      check("wr_rdata_keep", rdata_a, 16'h0000);
      check("wr_err", err_a, 1'b0);
      @(negedge clk);
      check("wr_done_width", done_a, 1'b0);

      // Read with PHY answering 16'h796D
      phy_en = 1'b1; phy_data = 16'h796D;
      do_frame(2'b10, 5'h01, 5'h02, 16'h0000, -1, bits, nrise, cyc, b0, be);
      check("rd_bits", bits, {32'hFFFF_FFFF, ST, 2'b10, 5'h01, 5'h02, 2'b10, 16'h796D});
      check("rd_rdata", rdata_a, 16'h796D);
      check("rd_err", err_a, 1'b0);
      check("rd_cycles", cyc, 256);
      phy_en = 1'b0;
      @(negedge clk);

`ifdef MDIO_CLAUSE45_EN
      do_frame(2'b00, 5'h02, 5'h01, 16'hABCD, -1, bits, nrise, cyc, b0, be);
      check("c45_addr_bits", bits, {32'hFFFF_FFFF, 2'b00, 2'b00, 5'h02, 5'h01, 2'b10, 16'hABCD});
      check("c45_cycles", cyc, 256);
      check("c45_err", err_a, 1'b0);
      check("c45_rdata_keep", rdata_a, 16'h796D);
      @(negedge clk);
`else
      op = 2'b11; pa = 5'h01; ra = 5'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rej_done", done_a, 1'b1);
      check("rej_err", err_a, 1'b1);
      check("rej_busy", busy_a, 1'b0);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (mdc_a || done_a || busy_a) cnt++;
      end
      check("rej_no_activity", cnt, 0);
      check("rej_err_hold", err_a, 1'b1);
      check("rej_rdata_keep", rdata_a, 16'h796D);
`endif

      // Write with a start raised mid-frame, which must be ignored
      do_frame(2'b01, 5'h05, 5'h0A, 16'hBEEF, 100, bits, nrise, cyc, b0, be);
      check("inj_bits", bits, {32'hFFFF_FFFF, ST, 2'b01, 5'h05, 5'h0A, 2'b10, 16'hBEEF});
      check("inj_cycles", cyc, 256);
      check("inj_err_clear", err_a, 1'b0);
      check("inj_rdata_keep", rdata_a, 16'h796D);
      repeat (10) @(negedge clk);
      check("inj_no_frame", busy_a, 1'b0);

      // Read with nothing driving the line but the pull-up
      do_frame(2'b10, 5'h03, 5'h04, 16'h0000, -1, bits, nrise, cyc, b0, be);
      check("nophy_rdata", rdata_a, 16'hFFFF);
      check("nophy_err", err_a, 1'b1);
      @(negedge clk);

      // Reset pulsed at bit 40 of a write frame
      op = 2'b01; pa = 5'h01; ra = 5'h00; wd = 16'h1140; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nrise = 0; cyc = 0; pm = 1'b0;
      while (nrise < 40 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (mdc_a && !pm) nrise++;
         pm = mdc_a;
      end
      #1;
      check("abort_pre_mdc", mdc_a, 1'b1);
      check("abort_pre_line", mdio_a, 1'b0);
      rst = 1'b1;
      #1;
      check("abort_mdc_low", mdc_a, 1'b0);
      check("abort_line_z", mdio_a, 1'b1);
      check("abort_busy", busy_a, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (done_a || mdc_a) cnt++;
      end
      check("abort_no_done", cnt, 0);
      do_frame(2'b01, 5'h01, 5'h00, 16'h1140, -1, bits, nrise, cyc, b0, be);
      check("after_rst_bits", bits, {32'hFFFF_FFFF, ST, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140});
      check("after_rst_cycles", cyc, 256);
      @(negedge clk);

      // Preamble suppressed
      sel = 1'b1;
      do_frame(2'b01, 5'h03, 5'h04, 16'hA5A5, -1, bits, nrise, cyc, b0, be);
      check("pl0_bits", bits, {32'h0, ST, 2'b01, 5'h03, 5'h04, 2'b10, 16'hA5A5});
      check("pl0_nrise", nrise, 32);
      check("pl0_cycles", cyc, 128);
      check("pl0_busy_at_done", be, 1'b0);
      sel = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
